// File: rtl/act_pkg.sv
// Shared function codes, FSM state type and Q6.10 constants for the activation scheduler.
package act_pkg;

  localparam logic [3:0] FUNC_SIGMOID = 4'b1111;
  localparam logic [3:0] FUNC_BYPASS  = 4'b0000;
  localparam logic [3:0] FUNC_RELU    = 4'b0001;

  localparam logic [15:0] ONE  = 16'h0400;
  localparam logic [15:0] HALF = 16'h0200;

  typedef enum logic {
    IDLE,
    BURST
  } state_t;

endpackage

// File: rtl/act_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after rr_ptr, wrapping modulo NREQ.
// Zero latency; no backpressure of its own.
module act_rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   rr_ptr,
  output logic [NREQ-1:0] gnt_oh,
  output logic [IW-1:0]   gnt_idx,
  output logic            gnt_vld
);

  int idx;

  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    idx     = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = (int'(rr_ptr) + i) % NREQ;
      if (!gnt_vld && req[idx]) begin
        gnt_vld     = 1'b1;
        gnt_oh[idx] = 1'b1;
        gnt_idx     = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/act_scheduler.sv
// Shares one sigmoid unit across NREQ requesters, round-robin per burst; result 2 cycles after accept, req_ready drops combinationally when both stages are full and rsp_ready is low.
// Optional macro ACT_SCHED_RELU_EN adds a local ReLU path for FUNC_RELU; without it that code is illegal.
module act_scheduler
  import act_pkg::*;
#(
  parameter int NREQ      = 2,
  parameter int DW        = 16,
  parameter int BURST_MAX = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*DW-1:0]      req_data,
  input  logic [NREQ*4-1:0]       req_func,
  input  logic [NREQ-1:0]         req_last,
  output logic [3:0]              act_ctrl,
  output logic [DW-1:0]           act_z,
  input  logic [DW-1:0]           act_dout,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DW-1:0]           rsp_data,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic                    rsp_last,
  output logic                    busy,
  output logic [1:0]              err
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(BURST_MAX + 1);

  function automatic logic func_legal(input logic [3:0] f);
    case (f)
      FUNC_SIGMOID, FUNC_BYPASS: return 1'b1;
`ifdef ACT_SCHED_RELU_EN
      FUNC_RELU:                 return 1'b1;
`endif
      default:                   return 1'b0;
    endcase
  endfunction

  state_t          state_q, state_d;
  logic [IW-1:0]   grant_q, grant_d, rr_ptr_q, rr_ptr_d;
  logic [NREQ-1:0] grant_oh_q, grant_oh_d;
  logic [CW-1:0]   burst_cnt_q, burst_cnt_d;
  logic [1:0]      err_q, err_d;

  logic            s1_vld_q, s1_vld_d, s1_last_q, s1_last_d;
  logic [DW-1:0]   s1_z_q, s1_z_d;
  logic [3:0]      s1_func_q, s1_func_d;
  logic [IW-1:0]   s1_id_q, s1_id_d;
  logic            s2_vld_q, s2_vld_d, s2_last_q, s2_last_d;
  logic [DW-1:0]   s2_dat_q, s2_dat_d;
  logic [IW-1:0]   s2_id_q, s2_id_d;

  logic [NREQ-1:0] arb_oh;
  logic [IW-1:0]   arb_idx;
  logic            arb_vld;
  logic            pipe_advance, s2_en, in_burst, accept, force_last, acc_last;
  logic [DW-1:0]   acc_dat, res;
  logic [3:0]      acc_func;

  act_rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
    .req     (req_valid),
    .rr_ptr  (rr_ptr_q),
    .gnt_oh  (arb_oh),
    .gnt_idx (arb_idx),
    .gnt_vld (arb_vld)
  );

  always_comb begin
    pipe_advance = !s1_vld_q || !s2_vld_q || rsp_ready;
    s2_en        = !s2_vld_q || rsp_ready;
    in_burst     = (state_q == BURST);
    acc_dat      = req_data[grant_q*DW +: DW];
    acc_func     = req_func[grant_q*4 +: 4];
    acc_last     = req_last[grant_q];
    accept       = in_burst && pipe_advance && req_valid[grant_q];
    // Element BURST_MAX of a grant closes the burst even without req_last.
    force_last   = accept && !acc_last && (burst_cnt_q == CW'(BURST_MAX - 1));
    req_ready    = (in_burst && pipe_advance) ? grant_oh_q : '0;
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    grant_oh_d  = grant_oh_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    err_d       = err_q;
    case (state_q)
      IDLE: begin
        if (arb_vld) begin
          grant_d    = arb_idx;
          grant_oh_d = arb_oh;
          state_d    = BURST;
        end
      end
      BURST: begin
        if (accept) begin
          if (acc_last || force_last) begin
            state_d     = IDLE;
            burst_cnt_d = '0;
            rr_ptr_d    = (grant_q == IW'(NREQ - 1)) ? '0 : grant_q + IW'(1);
          end else begin
            burst_cnt_d = burst_cnt_q + CW'(1);
          end
          if (force_last)           err_d[1] = 1'b1;
          if (!func_legal(acc_func)) err_d[0] = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    res = '0;
    case (s1_func_q)
      FUNC_SIGMOID: res = act_dout;
      FUNC_BYPASS:  res = s1_z_q;
`ifdef ACT_SCHED_RELU_EN
      FUNC_RELU:    res = s1_z_q[DW-1] ? '0 : s1_z_q;
`endif
      default:      res = '0;
    endcase
  end

  always_comb begin
    s1_vld_d  = s1_vld_q;
    s1_z_d    = s1_z_q;
    s1_func_d = s1_func_q;
    s1_id_d   = s1_id_q;
    s1_last_d = s1_last_q;
    s2_vld_d  = s2_vld_q;
    s2_dat_d  = s2_dat_q;
    s2_id_d   = s2_id_q;
    s2_last_d = s2_last_q;
    if (pipe_advance) begin
      s1_vld_d = accept;
      if (accept) begin
        s1_z_d    = acc_dat;
        s1_func_d = acc_func;
        s1_id_d   = grant_q;
        s1_last_d = acc_last || force_last;
      end
    end
    if (s2_en) begin
      s2_vld_d = s1_vld_q;
      if (s1_vld_q) begin
        s2_dat_d  = res;
        s2_id_d   = s1_id_q;
        s2_last_d = s1_last_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      grant_oh_q  <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
      err_q       <= '0;
      s1_vld_q    <= 1'b0;
      s1_z_q      <= '0;
      s1_func_q   <= '0;
      s1_id_q     <= '0;
      s1_last_q   <= 1'b0;
      s2_vld_q    <= 1'b0;
      s2_dat_q    <= '0;
      s2_id_q     <= '0;
      s2_last_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      grant_oh_q  <= grant_oh_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
      err_q       <= err_d;
      s1_vld_q    <= s1_vld_d;
      s1_z_q      <= s1_z_d;
      s1_func_q   <= s1_func_d;
      s1_id_q     <= s1_id_d;
      s1_last_q   <= s1_last_d;
      s2_vld_q    <= s2_vld_d;
      s2_dat_q    <= s2_dat_d;
      s2_id_q     <= s2_id_d;
      s2_last_q   <= s2_last_d;
    end
  end

  assign act_ctrl  = (s1_vld_q && s1_func_q == FUNC_SIGMOID) ? FUNC_SIGMOID : FUNC_BYPASS;
  assign act_z     = s1_z_q;
  assign rsp_valid = s2_vld_q;
  assign rsp_data  = s2_dat_q;
  assign rsp_id    = s2_id_q;
  assign rsp_last  = s2_last_q;
  assign busy      = (state_q != IDLE) || s1_vld_q || s2_vld_q;
  assign err       = err_q;

endmodule

// File: tb/tb_act_scheduler.sv
// Directed scoreboard bench for act_scheduler with a piecewise-linear sigmoid model as the external unit.
module tb_act_scheduler;
  import act_pkg::*;

  localparam int NREQ      = 2;
  localparam int DW        = 16;
  localparam int BURST_MAX = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid, req_ready, req_last;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ*4-1:0] req_func;
  logic [3:0]        act_ctrl;
  logic [DW-1:0]     act_z, act_dout, rsp_data;
  logic              rsp_valid, rsp_ready, rsp_last, busy;
  logic [0:0]        rsp_id;
  logic [1:0]        err;

  typedef struct {
    logic [15:0] z;
    logic [3:0]  func;
    logic        last;
  } elem_t;

  typedef struct {
    logic [15:0] dat;
    logic [0:0]  id;
    logic        last;
    int          acc;
    bit          lat;
  } exp_t;

  elem_t rq0[$];
  elem_t rq1[$];
  exp_t  sb[$];
  int    id_seq[$];
  int    bcnt[2];
  int    cyc = 0;
  int    n_chk = 0;
  int    n_pass = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] sig_model(input logic [15:0] z);
    if ($signed(z) >= 16'sh0800) return ONE;
    if ($signed(z) <= -16'sh0800) return 16'h0000;
    return HALF + 16'($signed(z) >>> 2);
  endfunction

  assign act_dout = (act_ctrl == 4'b1111) ? sig_model(act_z) : 16'hDEAD;

  function automatic logic [15:0] exp_res(input logic [15:0] z, input logic [3:0] f);
    case (f)
      FUNC_SIGMOID: return sig_model(z);
      FUNC_BYPASS:  return z;
`ifdef ACT_SCHED_RELU_EN
      FUNC_RELU:    return z[15] ? 16'h0000 : z;
`endif
      default:      return 16'h0000;
    endcase
  endfunction

  act_scheduler #(.NREQ(NREQ), .DW(DW), .BURST_MAX(BURST_MAX)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .req_func  (req_func),
    .req_last  (req_last),
    .act_ctrl  (act_ctrl),
    .act_z     (act_z),
    .act_dout  (act_dout),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .rsp_last  (rsp_last),
    .busy      (busy),
    .err       (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string pfx);
    chk({pfx, "_req_ready"}, 32'(req_ready), 0);
    chk({pfx, "_act_ctrl"},  32'(act_ctrl),  0);
    chk({pfx, "_act_z"},     32'(act_z),     0);
    chk({pfx, "_rsp_valid"}, 32'(rsp_valid), 0);
    chk({pfx, "_rsp_data"},  32'(rsp_data),  0);
    chk({pfx, "_rsp_id"},    32'(rsp_id),    0);
    chk({pfx, "_rsp_last"},  32'(rsp_last),  0);
    chk({pfx, "_busy"},      32'(busy),      0);
    chk({pfx, "_err"},       32'(err),       0);
  endtask

  // Output side: pop the scoreboard on every handshake.
  always @(negedge clk) begin
    exp_t x;
    if (!rst && rsp_valid && rsp_ready) begin
      chk("sb_nonempty", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        x = sb.pop_front();
        chk("rsp_data", 32'(rsp_data), 32'(x.dat));
        chk("rsp_id",   32'(rsp_id),   32'(x.id));
        chk("rsp_last", 32'(rsp_last), 32'(x.last));
        if (x.lat) chk("latency", 32'(cyc - x.acc), 2);
        if (rsp_last) id_seq.push_back(int'(rsp_id));
      end
    end
  end

  task automatic drive();
    req_valid = '0;
    if (rq0.size() != 0) begin
      req_valid[0]    = 1'b1;
      req_data[15:0]  = rq0[0].z;
      req_func[3:0]   = rq0[0].func;
      req_last[0]     = rq0[0].last;
    end
    if (rq1.size() != 0) begin
      req_valid[1]    = 1'b1;
      req_data[31:16] = rq1[0].z;
      req_func[7:4]   = rq1[0].func;
      req_last[1]     = rq1[0].last;
    end
  endtask

  task automatic run(input int max_cyc, input bit until_empty, input bit lat_chk,
                     input int stall_after, input int stall_len, input bit hold);
    int    n, acc_n, stall_done, prev_acc;
    bit    prev_last, lx;
    elem_t e;
    n = 0; acc_n = 0; stall_done = 0; prev_acc = 0; prev_last = 1'b0;
    while (n < max_cyc) begin
      drive();
      if (hold) rsp_ready = 1'b0;
      else if (stall_after >= 0 && acc_n >= stall_after && stall_done < stall_len) begin
        rsp_ready = 1'b0;
        stall_done++;
      end else rsp_ready = 1'b1;
      @(negedge clk);
      if (!hold && !rsp_ready) chk("bp_req_ready", 32'(req_ready), 0);
      for (int i = 0; i < 2; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          if (i == 0) e = rq0.pop_front();
          else        e = rq1.pop_front();
          lx = e.last || (bcnt[i] == BURST_MAX - 1);
          bcnt[i] = lx ? 0 : bcnt[i] + 1;
          if (prev_last) chk("burst_gap", 32'(cyc - prev_acc), 2);
          prev_last = lx;
          prev_acc  = cyc;
          acc_n++;
          sb.push_back('{exp_res(e.z, e.func), 1'(i), lx, cyc, lat_chk});
        end
      end
      @(posedge clk);
      #1;
      n++;
      if (until_empty && rq0.size() == 0 && rq1.size() == 0 && sb.size() == 0) break;
    end
    if (until_empty) chk("run_drained", 32'(rq0.size() + rq1.size() + sb.size()), 0);
    req_valid = '0;
    rsp_ready = 1'b1;
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_data = '0; req_func = '0; req_last = '0; rsp_ready = 1'b1;
    bcnt[0] = 0; bcnt[1] = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset("rst");
    @(posedge clk); #1 rst = 1'b0;

    // Sigmoid points on requester 0.
    rq0.push_back('{16'h0000, FUNC_SIGMOID, 1'b0});
    rq0.push_back('{16'h1800, FUNC_SIGMOID, 1'b0});
    rq0.push_back('{16'hE800, FUNC_SIGMOID, 1'b1});
    run(100, 1, 1, -1, 0, 0);

    // Forced release on requester 1: BURST_MAX+2 elements, last only on the final one.
    for (int i = 0; i < BURST_MAX + 2; i++)
      rq1.push_back('{16'(i + 1), FUNC_BYPASS, (i == BURST_MAX + 1)});
    run(400, 1, 1, -1, 0, 0);
    chk("err_forced", 32'(err), 32'h2);

    // Fairness: both requesters hold valid, 2-element bursts each.
    id_seq.delete();
    for (int i = 0; i < 4; i++) begin
      rq0.push_back('{16'(16'h0100 + i), FUNC_BYPASS, (i % 2 == 1)});
      rq1.push_back('{16'(16'h0200 + i), FUNC_BYPASS, (i % 2 == 1)});
    end
    run(100, 1, 1, -1, 0, 0);
    chk("fair_nbursts", 32'(id_seq.size()), 4);
    for (int i = 0; i < 4; i++)
      if (i < id_seq.size()) chk("fair_grant", 32'(id_seq[i]), 32'(i % 2));

    // Backpressure mid-burst of 8 bypass elements.
    for (int i = 1; i <= 8; i++) rq0.push_back('{16'(i), FUNC_BYPASS, (i == 8)});
    run(100, 1, 0, 3, 5, 0);

    // ReLU code on a negative operand.
    rq0.push_back('{16'hFC00, FUNC_RELU, 1'b1});
    run(50, 1, 1, -1, 0, 0);
`ifdef ACT_SCHED_RELU_EN
    chk("err_relu", 32'(err), 32'h2);
`else
    chk("err_relu", 32'(err), 32'h3);
`endif

    // Illegal function code.
    rq0.push_back('{16'h0123, 4'b0101, 1'b1});
    run(50, 1, 1, -1, 0, 0);
    chk("err_illegal", 32'(err), 32'h3);

    // Reset with both stages full on requester 1.
    for (int i = 0; i < 6; i++) rq1.push_back('{16'(16'h0010 + i), FUNC_BYPASS, 1'b0});
    run(6, 0, 0, -1, 0, 1);
    rst = 1'b1;
    #1;
    check_reset("rst_mid");
    rq1.delete(); sb.delete(); bcnt[0] = 0; bcnt[1] = 0;
    @(posedge clk); #1 rst = 1'b0;
    id_seq.delete();
    rq0.push_back('{16'h0055, FUNC_BYPASS, 1'b1});
    rq1.push_back('{16'h0066, FUNC_BYPASS, 1'b1});
    run(50, 1, 1, -1, 0, 0);
    chk("post_rst_n", 32'(id_seq.size()), 2);
    if (id_seq.size() > 0) chk("post_rst_first", 32'(id_seq[0]), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
